exe_pipe: RTL and testbench

EXE_PIPE -- requirements
Module: exe_pipe

---
 rtl/exe_pkg.sv | 30 +++
 rtl/exe_mul_iter.sv | 48 ++++
 rtl/exe_pipe.sv | 176 +++++++++++++++++
 tb/tb_exe_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, operand source
// selects and the execute FSM state type.
package exe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_e;

  // Any select with bit 1 set forces a zero operand.
  localparam logic [1:0] SRC1_RS1 = 2'b00;
  localparam logic [1:0] SRC1_PC  = 2'b01;
  localparam logic [1:0] SRC2_RS2 = 2'b00;
  localparam logic [1:0] SRC2_IMM = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exe_state_e;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier, one partial product per clock; only the low
// XLEN bits are kept. Used by exe_pipe when EXE_PIPE_MUL_EN is defined.
module exe_mul_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            word,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   iter_cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;

  assign busy = (iter_cnt != '0);
  // done marks the final iteration; product already includes its partial term
  assign done    = (iter_cnt == CW'(1));
  assign product = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
    end else if (start) begin
      iter_cnt <= word ? CW'(32) : CW'(XLEN);
      mcand    <= op_a;
      mplier   <= op_b;
      acc      <= '0;
    end else if (busy) begin
      iter_cnt <= iter_cnt - CW'(1);
      mcand    <= mcand << 1;
      mplier   <= mplier >> 1;
      acc      <= product;
    end
  end

endmodule

// File: rtl/exe_pipe.sv
// Execute stage: single-cycle ALU with one output register, plus an optional
// iterative multiplier enabled by the EXE_PIPE_MUL_EN macro.
//   state   | meaning
//   ST_IDLE | ready for a new instruction, output register may hold a result
//   ST_MUL  | multiplier iterating, output register waiting for the product
module exe_pipe
  import exe_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [1:0]      in_sel_src1,
  input  logic [1:0]      in_sel_src2,
  input  logic [3:0]      in_alu_op,
  input  logic            in_word,
  input  logic            in_sel_res,
  input  logic [RIDX-1:0] in_rd,
  input  logic            in_rf_wen,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_ram_addr,
  output logic [RIDX-1:0] out_rd,
  output logic            out_rf_wen
);

  localparam int SHW = $clog2(XLEN);

  exe_state_e             state;
  logic [XLEN-1:0]        src1;
  logic [XLEN-1:0]        src2;
  logic [XLEN-1:0]        res_x;
  logic [31:0]            res_w;
  logic signed [XLEN-1:0] res_w_ext;
  logic [XLEN-1:0]        alu_res;
  logic                   word_eff;
  logic                   accept;
  logic                   mul_busy;

  assign word_eff = (XLEN == 64) && in_word;
  assign in_ready = (state == ST_IDLE) && !mul_busy && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    src1 = '0;
    src2 = '0;
    if (in_sel_src1 == SRC1_RS1)     src1 = in_rs1_val;
    else if (in_sel_src1 == SRC1_PC) src1 = in_pc;
    if (in_sel_src2 == SRC2_RS2)      src2 = in_rs2_val;
    else if (in_sel_src2 == SRC2_IMM) src2 = in_imm;
  end

  // Full-width and 32-bit results are built side by side; in_word picks one.
  always_comb begin
    res_x = '0;
    res_w = '0;
    case (in_alu_op)
      ALU_ADD:  begin res_x = src1 + src2;  res_w = src1[31:0] + src2[31:0]; end
      ALU_SUB:  begin res_x = src1 - src2;  res_w = src1[31:0] - src2[31:0]; end
      ALU_SLL:  begin res_x = src1 << src2[SHW-1:0]; res_w = src1[31:0] << src2[4:0]; end
      ALU_SLT:  begin
        res_x = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
        res_w = {31'b0, $signed(src1[31:0]) < $signed(src2[31:0])};
      end
      ALU_SLTU: begin
        res_x = {{(XLEN-1){1'b0}}, src1 < src2};
        res_w = {31'b0, src1[31:0] < src2[31:0]};
      end
      ALU_XOR:  begin res_x = src1 ^ src2;  res_w = src1[31:0] ^ src2[31:0]; end
      ALU_SRL:  begin res_x = src1 >> src2[SHW-1:0]; res_w = src1[31:0] >> src2[4:0]; end
      ALU_SRA:  begin
        res_x = $signed(src1) >>> src2[SHW-1:0];
        res_w = $signed(src1[31:0]) >>> src2[4:0];
      end
      ALU_OR:   begin res_x = src1 | src2;  res_w = src1[31:0] | src2[31:0]; end
      ALU_AND:  begin res_x = src1 & src2;  res_w = src1[31:0] & src2[31:0]; end
      default:  begin res_x = '0;           res_w = '0;                      end
    endcase
  end

  assign res_w_ext = $signed(res_w);
  assign alu_res   = word_eff ? res_w_ext : res_x;

`ifdef EXE_PIPE_MUL_EN
  logic                   mul_start;
  logic                   mul_done;
  logic [XLEN-1:0]        mul_product;
  logic signed [XLEN-1:0] mul_lo_ext;
  logic [XLEN-1:0]        mul_res;
  logic                   mul_word_q;
  logic                   res_imm_q;

  assign mul_start  = accept && (in_alu_op == ALU_MUL);
  assign mul_lo_ext = $signed(mul_product[31:0]);
  assign mul_res    = mul_word_q ? mul_lo_ext : mul_product;

  exe_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst     (rst || flush),
    .start   (mul_start),
    .op_a    (src1),
    .op_b    (src2),
    .word    (word_eff),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_ram_addr <= '0;
      out_rd       <= '0;
      out_rf_wen   <= 1'b0;
`ifdef EXE_PIPE_MUL_EN
      mul_word_q   <= 1'b0;
      res_imm_q    <= 1'b0;
`endif
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            out_result   <= in_sel_res ? in_imm : alu_res;
            out_ram_addr <= in_rs1_val + in_imm;
            out_rd       <= in_rd;
            out_rf_wen   <= in_rf_wen;
`ifdef EXE_PIPE_MUL_EN
            if (in_alu_op == ALU_MUL) begin
              state      <= ST_MUL;
              out_valid  <= 1'b0;
              mul_word_q <= word_eff;
              res_imm_q  <= in_sel_res;
            end else begin
              out_valid <= 1'b1;
            end
`else
            out_valid <= 1'b1;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
`ifdef EXE_PIPE_MUL_EN
          // Sideband fields were captured at acceptance; only the result lands now.
          if (mul_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            if (!res_imm_q) out_result <= mul_res;
          end
`else
          state <= ST_IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_pipe.sv
// Scoreboard bench for exe_pipe (XLEN=64); expectations follow EXE_PIPE_MUL_EN.
`timescale 1ns/1ps
module tb_exe_pipe;
  import exe_pkg::*;

  localparam int XLEN = 64;
  localparam int RIDX = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1_val, in_rs2_val, in_pc, in_imm;
  logic [1:0]      in_sel_src1, in_sel_src2;
  logic [3:0]      in_alu_op;
  logic            in_word, in_sel_res;
  logic [RIDX-1:0] in_rd;
  logic            in_rf_wen;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result, out_ram_addr;
  logic [RIDX-1:0] out_rd;
  logic            out_rf_wen;

  exe_pipe #(.XLEN(XLEN), .RIDX(RIDX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_pc(in_pc), .in_imm(in_imm),
    .in_sel_src1(in_sel_src1), .in_sel_src2(in_sel_src2), .in_alu_op(in_alu_op),
    .in_word(in_word), .in_sel_res(in_sel_res), .in_rd(in_rd), .in_rf_wen(in_rf_wen),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ram_addr(out_ram_addr), .out_rd(out_rd),
    .out_rf_wen(out_rf_wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        word;
    logic [1:0]  s1, s2;
    logic        sel_res;
    logic [63:0] rs1, rs2, pc, imm;
    logic [4:0]  rd;
    logic        wen;
  } ins_t;

  typedef struct {
    logic [63:0] res, addr;
    logic [4:0]  rd;
    logic        wen;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  bit   rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] model(input ins_t i);
    logic [63:0] a, b, r;
    int unsigned sh;
    a = i.s1[1] ? 64'd0 : (i.s1[0] ? i.pc  : i.rs1);
    b = i.s2[1] ? 64'd0 : (i.s2[0] ? i.imm : i.rs2);
    if (i.sel_res) return i.imm;
    sh = i.word ? 32'(b[4:0]) : 32'(b[5:0]);
    r = 64'd0;
    if (i.word) begin
      case (i.op)
        ALU_ADD:  r = sx32(32'(a + b));
        ALU_SUB:  r = sx32(32'(a - b));
        ALU_SLL:  r = sx32(32'(a << sh));
        ALU_SLT:  r = ($signed(sx32(a[31:0])) < $signed(sx32(b[31:0]))) ? 64'd1 : 64'd0;
        ALU_SLTU: r = (a[31:0] < b[31:0]) ? 64'd1 : 64'd0;
        ALU_XOR:  r = sx32(32'(a ^ b));
        ALU_SRL:  r = sx32(32'({32'd0, a[31:0]} >> sh));
        ALU_SRA:  r = sx32(32'($signed(sx32(a[31:0])) >>> sh));
        ALU_OR:   r = sx32(32'(a | b));
        ALU_AND:  r = sx32(32'(a & b));
`ifdef EXE_PIPE_MUL_EN
        ALU_MUL:  r = sx32(32'(a * b));
`endif
        default:  r = 64'd0;
      endcase
    end else begin
      case (i.op)
        ALU_ADD:  r = a + b;
        ALU_SUB:  r = a - b;
        ALU_SLL:  r = a << sh;
        ALU_SLT:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        ALU_SLTU: r = (a < b) ? 64'd1 : 64'd0;
        ALU_XOR:  r = a ^ b;
        ALU_SRL:  r = a >> sh;
        ALU_SRA:  r = $signed(a) >>> sh;
        ALU_OR:   r = a | b;
        ALU_AND:  r = a & b;
`ifdef EXE_PIPE_MUL_EN
        ALU_MUL:  r = a * b;
`endif
        default:  r = 64'd0;
      endcase
    end
    return r;
  endfunction

  function automatic int latency(input ins_t i);
`ifdef EXE_PIPE_MUL_EN
    if (i.op == ALU_MUL) return i.word ? 33 : 65;
`endif
    return 1;
  endfunction

  function automatic ins_t mk(input logic [3:0] op, input logic word, input logic [1:0] s1,
                              input logic [1:0] s2, input logic sel_res, input logic [63:0] rs1,
                              input logic [63:0] rs2, input logic [63:0] imm);
    ins_t i;
    i.op = op; i.word = word; i.s1 = s1; i.s2 = s2; i.sel_res = sel_res;
    i.rs1 = rs1; i.rs2 = rs2; i.pc = 64'h0000_0000_8000_1000; i.imm = imm;
    i.rd = 5'($urandom); i.wen = 1'($urandom);
    return i;
  endfunction

  task automatic apply(input ins_t i);
    in_alu_op = i.op; in_word = i.word; in_sel_src1 = i.s1; in_sel_src2 = i.s2;
    in_sel_res = i.sel_res; in_rs1_val = i.rs1; in_rs2_val = i.rs2; in_pc = i.pc;
    in_imm = i.imm; in_rd = i.rd; in_rf_wen = i.wen;
  endtask

  // Called at a negedge where the instruction is seen accepted at the next edge.
  task automatic push_exp(input ins_t i, input logic [63:0] er, input bit lat);
    exp_t e;
    e.res = er; e.addr = i.rs1 + i.imm; e.rd = i.rd; e.wen = i.wen;
    e.cyc = cyc + latency(i); e.lat = lat;
    sbq.push_back(e);
  endtask

  // Entered just after a posedge; returns just after the accepting posedge.
  task automatic send(input ins_t i, input logic [63:0] er, input bit expect_out, input bit lat);
    bit got;
    got = 0;
    apply(i);
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    chk("accept", 64'(got), 64'd1);
    if (got && expect_out) push_exp(i, er, lat);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("out_expected", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        me = sbq.pop_front();
        chk("result", out_result, me.res);
        chk("ram_addr", out_ram_addr, me.addr);
        chk("rd", 64'(out_rd), 64'(me.rd));
        chk("rf_wen", 64'(out_rf_wen), 64'(me.wen));
        if (me.lat) chk("latency", 64'(cyc), 64'(me.cyc));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom);
    end
  end

  ins_t ia, ib, ic, ir;
  ins_t dir[$];
  int   n;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    apply(mk(4'd0, 0, 2'b00, 2'b00, 0, 64'd0, 64'd0, 64'd0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_addr", out_ram_addr, 64'd0);
    chk("rst_rd", 64'(out_rd), 64'd0);
    chk("rst_wen", 64'(out_rf_wen), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Worked examples with hand-computed results
    ia = mk(ALU_ADD, 0, SRC1_RS1, SRC2_IMM, 0, 64'd5, 64'd99, -64'sd3);
    send(ia, 64'd2, 1, 1);
    ia = mk(ALU_SRA, 1, SRC1_RS1, SRC2_RS2, 0, 64'h0000_0000_8000_0000, 64'd4, 64'd0);
    send(ia, 64'hFFFF_FFFF_F800_0000, 1, 1);

    // Back-to-back directed table, latency checked
    dir.push_back(mk(ALU_SUB,  0, SRC1_RS1, SRC2_RS2, 0, 64'd3, 64'd10, 64'd0));
    dir.push_back(mk(ALU_SLL,  0, SRC1_RS1, SRC2_RS2, 0, 64'h1, 64'd63, 64'd0));
    dir.push_back(mk(ALU_SLL,  1, SRC1_RS1, SRC2_RS2, 0, 64'h1, 64'd31, 64'd0));
    dir.push_back(mk(ALU_SLT,  0, SRC1_RS1, SRC2_RS2, 0, -64'sd1, 64'd1, 64'd0));
    dir.push_back(mk(ALU_SLTU, 0, SRC1_RS1, SRC2_RS2, 0, -64'sd1, 64'd1, 64'd0));
    dir.push_back(mk(ALU_SLT,  1, SRC1_RS1, SRC2_RS2, 0, 64'h0000_0001_8000_0000, 64'd0, 64'd0));
    dir.push_back(mk(ALU_XOR,  0, SRC1_PC,  SRC2_IMM, 0, 64'd0, 64'd0, 64'hFF));
    dir.push_back(mk(ALU_SRL,  1, SRC1_RS1, SRC2_RS2, 0, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'd0));
    dir.push_back(mk(ALU_SRA,  0, SRC1_RS1, SRC2_IMM, 0, 64'h8000_0000_0000_0000, 64'd0, 64'd3));
    dir.push_back(mk(ALU_OR,   0, 2'b10,    SRC2_RS2, 0, 64'h55, 64'hA0, 64'd0));
    dir.push_back(mk(ALU_AND,  0, SRC1_RS1, 2'b11,    0, 64'hFFFF, 64'hFF, 64'd0));
    dir.push_back(mk(ALU_ADD,  1, SRC1_RS1, SRC2_RS2, 0, 64'h7FFF_FFFF, 64'd1, 64'd0));
    dir.push_back(mk(ALU_ADD,  0, SRC1_RS1, SRC2_RS2, 1, 64'd1, 64'd2, 64'h1234_5678));
    dir.push_back(mk(4'd15,    0, SRC1_RS1, SRC2_RS2, 0, 64'd7, 64'd9, 64'd0));
    dir.push_back(mk(ALU_MUL,  1, SRC1_RS1, SRC2_RS2, 0, 64'h1234_5678, 64'h10, 64'd0));
    foreach (dir[k]) send(dir[k], model(dir[k]), 1, 1);

    // MUL 7 * -6: busy window, then -42
    ia = mk(ALU_MUL, 0, SRC1_RS1, SRC2_RS2, 0, 64'd7, -64'sd6, 64'd0);
`ifdef EXE_PIPE_MUL_EN
    send(ia, 64'hFFFF_FFFF_FFFF_FFD6, 1, 1);
`else
    send(ia, 64'd0, 1, 1);
`endif
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
`ifdef EXE_PIPE_MUL_EN
    chk("mul_busy_cycles", 64'(n), 64'd64);
`else
    chk("mul_busy_cycles", 64'(n), 64'd0);
`endif
    @(posedge clk); #1;

    // Output stall for 3 cycles, then no-bubble release
    out_ready = 1'b0;
    ia = mk(ALU_XOR, 0, SRC1_RS1, SRC2_RS2, 0, 64'hDEAD_BEEF_0000_1111, 64'h0F0F, 64'd8);
    send(ia, model(ia), 1, 0);
    ib = mk(ALU_ADD, 0, SRC1_RS1, SRC2_IMM, 0, 64'd100, 64'd0, 64'd23);
    apply(ib);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_result", out_result, model(ia));
      chk("stall_addr", out_ram_addr, ia.rs1 + ia.imm);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    push_exp(ib, 64'd123, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    // Flush kills a held result and blocks the flush-cycle instruction
    out_ready = 1'b0;
    ia = mk(ALU_OR, 0, SRC1_RS1, SRC2_RS2, 0, 64'h1, 64'h2, 64'd0);
    send(ia, 64'd0, 0, 0);
    ic = mk(ALU_ADD, 0, SRC1_RS1, SRC2_RS2, 0, 64'd1, 64'd1, 64'd0);
    apply(ic);
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_held_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_held_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

`ifdef EXE_PIPE_MUL_EN
    // Flush at iteration 10 of a MUL
    ia = mk(ALU_MUL, 0, SRC1_RS1, SRC2_RS2, 0, 64'd3, 64'd5, 64'd0);
    send(ia, 64'd0, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    apply(ic);
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_mul_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_mul_idle", 64'(in_ready), 64'd1);
    n = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("flush_mul_no_out", 64'(n), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a MUL
    send(ia, 64'd0, 0, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mul_in_ready", 64'(in_ready), 64'd1);
    n = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("rst_mul_no_out", 64'(n), 64'd0);
    @(posedge clk); #1;
`endif

    // Random traffic with random backpressure
    rnd_ready = 1;
    for (int k = 0; k < 60; k++) begin
      ir = mk(4'($urandom_range(0, 15)), 1'($urandom), 2'($urandom), 2'($urandom),
              ($urandom_range(0, 7) == 0), {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom});
      send(ir, model(ir), 1, 0);
    end
    rnd_ready = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    chk("drain", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
